store_buffer: RTL
=================

Name: store_buffer

Overview:
- Posted-write buffer directly downstream of the single-cycle core's data-memory port.
- Accepts stores (MemWrite, ALUResult, WriteData) in one cycle and drains them in order to data memory over a req/ack handshake.
- Forwards buffered store data to same-cycle loads, so ReadData stays coherent while stores are pending.

Parameters:
- DEPTH, 4, number of store entries; power of two, at least 2.
- ADDR_W, 32, address width.
- DATA_W, 32, data width; word granularity only, no byte enables.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-high reset.
- st_valid  input  1  store request (core MemWrite).
- st_addr  input  ADDR_W  store address (core ALUResult).
- st_data  input  DATA_W  store data (core WriteData).
- st_full  output  1  buffer full; core must stall the store.
- ld_addr  input  ADDR_W  load address for forwarding lookup.
- ld_hit  output  1  a buffered entry matches ld_addr.
- ld_data  output  DATA_W  forwarded data, valid when ld_hit=1.
- mem_req  output  1  head entry presented to memory.
- mem_addr  output  ADDR_W  head address.
- mem_wdata  output  DATA_W  head data.
- mem_ack  input  1  memory accepted the head this cycle.
- err_overflow  output  1  sticky; a store arrived while full.

Behaviour:
- Storage is a circular FIFO with head pointer, tail pointer (log2(DEPTH) bits, natural wrap) and count (log2(DEPTH)+1 bits); all are registers.
- Reset (async, any time, including mid-handshake): count=0, both pointers=0, err_overflow=0. mem_req, st_full and ld_hit drop to 0 immediately. Entry contents are don't-care. Memory must discard an unacked request.
- st_full = (count==DEPTH); combinational from the registered count.
- Push: on a clock edge with st_valid=1 and st_full=0, write {st_addr, st_data} at tail and advance tail.
- Overflow: st_valid=1 with st_full=1 is rejected, state is unchanged and err_overflow sets. This holds even if mem_ack=1 in the same cycle.
- Drain: mem_req = (count!=0). mem_addr and mem_wdata come from the head entry and stay stable while mem_req=1 and mem_ack=0.
- Pop: on an edge with mem_req=1 and mem_ack=1, advance head. mem_ack while mem_req=0 is ignored.
- Push and pop on the same edge (not full): count is unchanged and both pointers advance.
- Latency: a store pushed into an empty buffer appears on mem_req in the next cycle. Zero-wait-state memory sustains one store per cycle.
- Ordering: strict FIFO; memory sees stores in program order.
- Forwarding (combinational):
  - Compare ld_addr[ADDR_W-1:2] against all valid entries.
  - The youngest match wins; ld_hit=1 and ld_data is that entry's data.
  - An entry being popped in the current cycle is still valid and forwardable.
  - A store on st_* in the same cycle is not forwarded.
- No-match case: ld_hit=0 and ld_data=0; the consumer then takes data from memory.

Optional Feature:
- Macro: STORE_BUF_COALESCE_EN.
- Defined: if st_valid=1, count>=2 and st_addr word address equals the youngest entry (tail-1), that entry's data is overwritten and no push occurs. This is permitted even when full and does not set err_overflow. The head entry is never coalesced; with count==1 the store enqueues normally.
- Undefined: every accepted store allocates a new entry.

Test Plan:
- Reset, then st_valid with addr 0x100, data 0xAAAA5555 and mem_ack held 0 -> next cycle mem_req=1, mem_addr=0x100, mem_wdata=0xAAAA5555, stable for 5 cycles; mem_ack pulse -> mem_req=0.
- Push 4 stores (0x0,0x4,0x8,0xC) with mem_ack=0 -> st_full=1; 5th store to 0x10 -> rejected, err_overflow=1. Then ack 4 times -> drain order 0x0,0x4,0x8,0xC.
- Stores 0x20/0x11, then 0x20/0x22 -> ld_addr=0x20 gives ld_hit=1, ld_data=0x22; ld_addr=0x23 also hits; ld_addr=0x24 gives ld_hit=0, ld_data=0.
- mem_ack held 1, store every cycle for 10 cycles -> st_full never asserts, count stays at most 1, all 10 addresses appear in order, pointers wrap.
- Assert reset while mem_req=1 with 3 entries -> mem_req=0 the same cycle; after release, count=0 and ld_hit=0.
- With STORE_BUF_COALESCE_EN: stores 0x40/1, 0x44/2, 0x44/3 with mem_ack=0 -> only 2 entries; the second drains data 3.

Source files
------------

// File: rtl/store_buffer.sv
// ============================================================================
// Module   : store_buffer
// Purpose  : Posted-write FIFO between core data port and data memory, with
//            youngest-match load forwarding. Optional: STORE_BUF_COALESCE_EN.
// Revision : 1.0
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module store_buffer #(
  parameter int DEPTH  = 4,
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              st_valid,
  input  logic [ADDR_W-1:0] st_addr,
  input  logic [DATA_W-1:0] st_data,
  output logic              st_full,
  input  logic [ADDR_W-1:0] ld_addr,
  output logic              ld_hit,
  output logic [DATA_W-1:0] ld_data,
  output logic              mem_req,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic              mem_ack,
  output logic              err_overflow
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [PTR_W-1:0] C_PTR_ONE  = PTR_W'(1);
  localparam logic [PTR_W:0]   C_CNT_ONE  = (PTR_W+1)'(1);
  localparam logic [PTR_W:0]   C_CNT_FULL = (PTR_W+1)'(DEPTH);

  logic [ADDR_W-1:0] r_addr [DEPTH];
  logic [DATA_W-1:0] r_data [DEPTH];
  logic [PTR_W-1:0]  r_head;
  logic [PTR_W-1:0]  r_tail;
  logic [PTR_W:0]    r_count;
  logic              r_err;

  logic w_full;
  logic w_push;
  logic w_pop;
  logic w_coalesce;
  logic w_overflow;
  logic w_unused_ld_lsb;

  assign w_full  = (r_count == C_CNT_FULL);
  assign st_full = w_full;
  assign mem_req = (r_count != '0);
  assign mem_addr  = r_addr[r_head];
  assign mem_wdata = r_data[r_head];
  assign err_overflow = r_err;
  assign w_unused_ld_lsb = ^ld_addr[1:0];

`ifdef STORE_BUF_COALESCE_EN
  localparam logic [PTR_W:0] C_CNT_TWO = (PTR_W+1)'(2);
  logic [PTR_W-1:0] w_young_idx;

  // The head may be mid-handshake, so only a non-head youngest entry merges.
  assign w_young_idx = r_tail - C_PTR_ONE;
  assign w_coalesce  = st_valid && (r_count >= C_CNT_TWO) &&
                       (st_addr[ADDR_W-1:2] == r_addr[w_young_idx][ADDR_W-1:2]);
`else
  assign w_coalesce = 1'b0;
`endif

  assign w_push     = st_valid && !w_full && !w_coalesce;
  assign w_overflow = st_valid &&  w_full && !w_coalesce;
  assign w_pop      = mem_req && mem_ack;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
      r_err   <= 1'b0;
    end else begin
      if (w_push) r_tail <= r_tail + C_PTR_ONE;
      if (w_pop)  r_head <= r_head + C_PTR_ONE;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + C_CNT_ONE;
        2'b01:   r_count <= r_count - C_CNT_ONE;
        default: r_count <= r_count;
      endcase
      if (w_overflow) r_err <= 1'b1;
    end
  end

  // Entry payload needs no reset; validity is carried entirely by r_count.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_addr[r_tail] <= st_addr;
      r_data[r_tail] <= st_data;
    end
`ifdef STORE_BUF_COALESCE_EN
    if (w_coalesce) r_data[w_young_idx] <= st_data;
`endif
  end

  // Walk oldest to youngest so the last match (youngest) wins.
  always_comb begin
    logic [PTR_W-1:0] v_idx;
    ld_hit  = 1'b0;
    ld_data = '0;
    v_idx   = '0;
    for (int i = 0; i < DEPTH; i++) begin
      v_idx = r_head + PTR_W'(i);
      if (((PTR_W+1)'(i) < r_count) &&
          (r_addr[v_idx][ADDR_W-1:2] == ld_addr[ADDR_W-1:2])) begin
        ld_hit  = 1'b1;
        ld_data = r_data[v_idx];
      end
    end
  end

endmodule

`default_nettype wire
